// File: rtl/setting_reg_bank_if.sv
// rtl/setting_reg_bank_if.sv - settings-bus write and readback signals for setting_reg_bank
interface setting_reg_bank_if;
   logic        strobe;
   logic [7:0]  addr;
   logic [31:0] data_in;
   logic        rb_stb;
   logic [7:0]  rb_addr;
   logic [31:0] rb_data;
   logic        rb_valid;

   modport master (
      output strobe, addr, data_in, rb_stb, rb_addr,
      input  rb_data, rb_valid
   );

   modport slave (
      input  strobe, addr, data_in, rb_stb, rb_addr,
      output rb_data, rb_valid
   );
endinterface

// File: rtl/setting_reg_bank.sv
// rtl/setting_reg_bank.sv - settings register bank with optional shadow/commit and readback
module setting_reg_bank #(
   parameter int          BASE      = 0,
   parameter int          NUM_REGS  = 4,
   parameter int          WIDTH     = 32,
   parameter logic [31:0] RESET_VAL = 32'h0,
   parameter int          SHADOW    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   setting_reg_bank_if.slave         bus,
   output logic [NUM_REGS*WIDTH-1:0] o_out,
   output logic [NUM_REGS-1:0]       o_changed,
   output logic [NUM_REGS-1:0]       o_pending
);
   localparam logic [WIDTH-1:0] RV     = RESET_VAL[WIDTH-1:0];
   localparam logic [8:0]       LO     = 9'(BASE);
   localparam logic [8:0]       HI     = 9'(BASE + NUM_REGS);
   localparam logic [7:0]       CA     = 8'(BASE + NUM_REGS);

   logic [WIDTH-1:0]    r_val    [NUM_REGS];
   logic [WIDTH-1:0]    r_shadow [NUM_REGS];
   logic [NUM_REGS-1:0] r_changed;
   logic [NUM_REGS-1:0] r_pending;
   logic [31:0]         r_rb_data;
   logic                r_rb_valid;

   logic                w_hit;
   logic                w_commit;
   logic [7:0]          w_off;
   logic                w_rb_hit;
   logic [7:0]          w_rb_off;
   logic [31:0]         w_rb_word;
   logic                w_unused;

   assign w_hit    = bus.strobe && ({1'b0, bus.addr} >= LO) && ({1'b0, bus.addr} < HI);
   assign w_commit = (SHADOW != 0) && bus.strobe && (bus.addr == CA);
   assign w_off    = bus.addr - LO[7:0];
   assign w_rb_hit = ({1'b0, bus.rb_addr} >= LO) && ({1'b0, bus.rb_addr} < HI);
   assign w_rb_off = bus.rb_addr - LO[7:0];
   assign w_unused = ^bus.data_in;

   always_comb begin
      w_rb_word = '0;
      o_out     = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         o_out[i*WIDTH +: WIDTH] = r_val[i];
         if (w_rb_hit && w_rb_off == 8'(i))
            w_rb_word = 32'(r_val[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_val[i]    <= RV;
            r_shadow[i] <= RV;
         end
         r_changed  <= '0;
         r_pending  <= '0;
         r_rb_data  <= '0;
         r_rb_valid <= 1'b0;
      end else begin
         r_changed <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (SHADOW == 0) begin
               if (w_hit && w_off == 8'(i)) begin
                  r_val[i]     <= bus.data_in[WIDTH-1:0];
                  r_changed[i] <= 1'b1;
               end
            end else if (w_hit && w_off == 8'(i)) begin
               r_shadow[i]  <= bus.data_in[WIDTH-1:0];
               r_pending[i] <= 1'b1;
            end else if (w_commit && r_pending[i]) begin
               // all pending registers flip on the same edge
               r_val[i]     <= r_shadow[i];
               r_changed[i] <= 1'b1;
               r_pending[i] <= 1'b0;
            end
         end
         r_rb_valid <= bus.rb_stb;
         if (bus.rb_stb)
            r_rb_data <= w_rb_word;
      end
   end

   assign o_changed    = r_changed;
   assign o_pending    = r_pending;
   assign bus.rb_data  = r_rb_data;
   assign bus.rb_valid = r_rb_valid;
endmodule

// File: tb/tb_setting_reg_bank.sv
// tb/tb_setting_reg_bank.sv - directed checks of setting_reg_bank in direct and shadow modes
module tb_setting_reg_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   setting_reg_bank_if b0 ();
   setting_reg_bank_if b1 ();

   logic [63:0]  out0;
   logic [3:0]   chg0, pend0;
   logic [127:0] out1;
   logic [3:0]   chg1, pend1;

   setting_reg_bank #(.BASE(8), .NUM_REGS(4), .WIDTH(16), .RESET_VAL(32'h0), .SHADOW(0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(b0.slave),
      .o_out(out0), .o_changed(chg0), .o_pending(pend0)
   );

   setting_reg_bank #(.BASE(8), .NUM_REGS(4), .WIDTH(32), .RESET_VAL(32'hA5), .SHADOW(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(b1.slave),
      .o_out(out1), .o_changed(chg1), .o_pending(pend1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b0.strobe = 0; b0.addr = 0; b0.data_in = 0; b0.rb_stb = 0; b0.rb_addr = 0;
      b1.strobe = 0; b1.addr = 0; b1.data_in = 0; b1.rb_stb = 0; b1.rb_addr = 0;
   endtask

   task automatic wr0(input logic [7:0] a, input logic [31:0] d);
      b0.strobe = 1; b0.addr = a; b0.data_in = d;
      tick();
      b0.strobe = 0;
   endtask

   task automatic wr1(input logic [7:0] a, input logic [31:0] d);
      b1.strobe = 1; b1.addr = a; b1.data_in = d;
      tick();
      b1.strobe = 0;
   endtask

   localparam logic [127:0] ALL_A5 = {4{32'h0000_00A5}};

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;
      check("rst_out0", out0, 64'h0);
      check("rst_chg0", chg0, 4'b0000);
      check("rst_pend0", pend0, 4'b0000);
      check("rst_rbv0", b0.rb_valid, 1'b0);
      check("rst_rbd0", b0.rb_data, 32'h0);
      check("rst_out1", out1, ALL_A5);
      check("rst_pend1", pend1, 4'b0000);

      // direct mode: only low 16 bits stored
      wr0(8'd9, 32'hABCD_1234);
      check("wr9_out", out0, 64'h0000_0000_1234_0000);
      check("wr9_chg", chg0, 4'b0010);
      tick();
      check("wr9_chg_off", chg0, 4'b0000);
      check("wr9_hold", out0, 64'h0000_0000_1234_0000);

      wr0(8'd7, 32'hFFFF_FFFF);
      check("below_out", out0, 64'h0000_0000_1234_0000);
      check("below_chg", chg0, 4'b0000);
      wr0(8'd12, 32'hFFFF_FFFF);
      check("above_out", out0, 64'h0000_0000_1234_0000);
      check("above_chg", chg0, 4'b0000);

      wr0(8'd11, 32'h0000_5555);
      check("wr11_out", out0, 64'h5555_0000_1234_0000);
      check("wr11_chg", chg0, 4'b1000);

      // readback and write of the same register on one edge
      b0.rb_stb = 1; b0.rb_addr = 8'd9;
      b0.strobe = 1; b0.addr = 8'd9; b0.data_in = 32'd3;
      tick();
      b0.strobe = 0; b0.rb_stb = 0;
      check("rb_pre_data", b0.rb_data, 32'h1234);
      check("rb_pre_valid", b0.rb_valid, 1'b1);
      check("rb_pre_out", out0, 64'h5555_0000_0003_0000);
      tick();
      check("rb_idle_valid", b0.rb_valid, 1'b0);
      check("rb_idle_hold", b0.rb_data, 32'h1234);
      b0.rb_stb = 1; b0.rb_addr = 8'd200;
      tick();
      b0.rb_stb = 0;
      check("rb_oob_data", b0.rb_data, 32'h0);
      check("rb_oob_valid", b0.rb_valid, 1'b1);
      b0.rb_stb = 1; b0.rb_addr = 8'd11;
      tick();
      b0.rb_stb = 0;
      check("rb11_data", b0.rb_data, 32'h5555);

      wr0(8'd9, 32'd3);
      check("same_val_chg", chg0, 4'b0010);
      check("same_val_out", out0, 64'h5555_0000_0003_0000);

      // shadow mode staging and commit
      wr1(8'd8, 32'd5);
      wr1(8'd10, 32'd7);
      check("stage_pend", pend1, 4'b0101);
      check("stage_out", out1, ALL_A5);
      check("stage_chg", chg1, 4'b0000);
      wr1(8'd12, 32'hDEAD_BEEF);
      check("commit_out", out1, {32'hA5, 32'd7, 32'hA5, 32'd5});
      check("commit_chg", chg1, 4'b0101);
      check("commit_pend", pend1, 4'b0000);
      tick();
      check("commit_chg_off", chg1, 4'b0000);

      wr1(8'd8, 32'd1);
      wr1(8'd8, 32'd2);
      check("rewrite_pend", pend1, 4'b0001);
      wr1(8'd12, 32'd0);
      check("lastwin_out", out1, {32'hA5, 32'd7, 32'hA5, 32'd2});
      check("lastwin_chg", chg1, 4'b0001);
      wr1(8'd12, 32'd0);
      check("empty_commit_out", out1, {32'hA5, 32'd7, 32'hA5, 32'd2});
      check("empty_commit_chg", chg1, 4'b0000);

      b1.rb_stb = 1; b1.rb_addr = 8'd10;
      tick();
      b1.rb_stb = 0;
      check("rb1_data", b1.rb_data, 32'd7);

      // reset discards staged data
      wr1(8'd8, 32'd9);
      check("pre_rst_pend", pend1, 4'b0001);
      rst = 1;
      tick();
      rst = 0;
      wr1(8'd12, 32'd0);
      check("post_rst_out", out1, ALL_A5);
      check("post_rst_pend", pend1, 4'b0000);
      check("post_rst_chg", chg1, 4'b0000);
      check("post_rst_out0", out0, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
